decode_stage: RTL and testbench
===============================

# decode_stage

Registered instruction-decode stage between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and runs it through `opdecoder` and `imm_gen`. It presents the instruction, PC, opcode class code and 64-bit sign-extended immediate from an output register. A one-entry skid buffer keeps `in_ready` a pure register output, and a flush input drops everything in flight for branch/jump redirects.

## Interface

- `PC_W`, 64, width of the program counter carried alongside each instruction
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  fetch presents an instruction
- `in_ready`  output  1  stage can accept; registered, not combinational on `out_ready`
- `in_insn`  input  32  raw instruction
- `in_pc`  input  PC_W  instruction address
- `flush`  input  1  discard all held instructions at next edge
- `out_valid`  output  1  decoded instruction available
- `out_ready`  input  1  execute consumes the output this cycle
- `out_insn`  output  32  registered instruction
- `out_pc`  output  PC_W  registered PC
- `out_code`  output  32  `opdecoder` code for `out_insn[6:0]`
- `out_imm`  output  64  `imm_gen` immediate for `out_insn`/`out_code`
- `out_illegal`  output  1  `out_code` is all zero (unrecognised opcode)

## Operation

- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Decode is combinational on the incoming word, from either the skid entry or `in_insn`.
- Results are captured into the output register with the instruction and PC, so `out_*` never change combinationally.
- Immediate rules are those of `imm_gen`:
  - U: `{sext32, insn[31:12], 12'b0}`
  - J: `{sext44, insn[19:12], insn[20], insn[30:21], 0}`
  - I / JALR / LOAD / CSR: `sext52, insn[31:20]`
  - B: `{sext52, insn[7], insn[30:25], insn[11:8], 0}`
  - S: `{sext52, insn[31:25], insn[11:7]}`
- Three-state FSM:
  - EMPTY: `out_valid=0`, `in_ready=1`. An input transfer moves to FULL.
  - FULL: `out_valid=1`, `in_ready=1`.
    - Input with output transfer: output reloads, stay FULL.
    - Input without output transfer: incoming word goes to skid, go to SKID.
    - Output transfer only: go to EMPTY.
  - SKID: `out_valid=1`, `in_ready=0`. On output transfer, the skid word is decoded into the output register and the stage goes to FULL. No input is accepted while in SKID.
- Order is strictly FIFO: the skid word always issues before any newer input.
- Flush has priority over everything:
  - Next state is EMPTY and `out_valid` is cleared.
  - The skid entry is invalidated.
  - An input transfer in the same cycle is discarded.
  - An output transfer in the same cycle still counts as consumed by execute.
- Reset is asynchronous and may occur mid-operation. It forces EMPTY immediately.

## Timing

- Latency: an instruction accepted at edge N is on `out_*` with `out_valid=1` after edge N. One cycle, no bypass.
- Throughput: one instruction per cycle while `out_ready=1`.
- `in_ready` falls the cycle after the output stalls while FULL, and rises the cycle after the SKID entry drains.
- Reset values: `out_valid=0`, `in_ready=1`, and `out_insn`, `out_pc`, `out_code`, `out_imm`, `out_illegal` all 0.
- After reset deasserts, the first input is accepted on the first rising edge.
- `out_*` data hold stable while `out_valid && !out_ready`.

## Test plan

- Reset, then send `in_insn=0x12345037` (LUI) with `in_pc=0x1000`.
  - After one edge: `out_valid=1`, `out_imm=0x0000000012345000`, `out_pc=0x1000`, `out_illegal=0`.
- Sign-extension cases:
  - `0x800000B7` gives `out_imm=0xFFFFFFFF80000000`.
  - `0xFFF00093` (addi -1) gives `0xFFFFFFFFFFFFFFFF`.
  - `0xFE000EE3` (beq -4) gives `0xFFFFFFFFFFFFFFFC`.
- Back-pressure: stream A, B, C with `out_ready=0` from the cycle A appears.
  - B lands in skid and `in_ready` drops. C is held by fetch.
  - Raise `out_ready`: outputs are A, B, C on consecutive cycles, none lost or duplicated.
- Flush in SKID with `in_valid=1` the same cycle.
  - Next cycle: `out_valid=0`, `in_ready=1`, and the flushed input never appears.
  - A following instruction issues normally.
- Assert `reset` asynchronously mid-stream between edges.
  - `out_valid` drops to 0 and `in_ready` goes to 1 without waiting for a clock edge.
- Opcode `0x7F` (`in_insn=0xFFFFFFFF`) gives `out_illegal=1`. The handshake proceeds normally.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with one-entry skid buffer, opdecoder and imm_gen
package decode_pkg;
    localparam int C_LUI       = 0;
    localparam int C_AUIPC     = 1;
    localparam int C_JAL       = 2;
    localparam int C_JALR      = 3;
    localparam int C_BRANCH    = 4;
    localparam int C_LOAD      = 5;
    localparam int C_STORE     = 6;
    localparam int C_OP_IMM    = 7;
    localparam int C_OP        = 8;
    localparam int C_OP_IMM_32 = 9;
    localparam int C_OP_32     = 10;
    localparam int C_MISC_MEM  = 11;
    localparam int C_SYSTEM    = 12;
    localparam int C_AMO       = 13;
endpackage

// One-hot opcode class; all zero for an unrecognised opcode.
module opdecoder
    import decode_pkg::*;
(
    input  logic [6:0]  opcode,
    output logic [31:0] code
);
    always_comb begin
        code = '0;
        case (opcode)
            7'h37: code[C_LUI]       = 1'b1;
            7'h17: code[C_AUIPC]     = 1'b1;
            7'h6F: code[C_JAL]       = 1'b1;
            7'h67: code[C_JALR]      = 1'b1;
            7'h63: code[C_BRANCH]    = 1'b1;
            7'h03: code[C_LOAD]      = 1'b1;
            7'h23: code[C_STORE]     = 1'b1;
            7'h13: code[C_OP_IMM]    = 1'b1;
            7'h33: code[C_OP]        = 1'b1;
            7'h1B: code[C_OP_IMM_32] = 1'b1;
            7'h3B: code[C_OP_32]     = 1'b1;
            7'h0F: code[C_MISC_MEM]  = 1'b1;
            7'h73: code[C_SYSTEM]    = 1'b1;
            7'h2F: code[C_AMO]       = 1'b1;
            default: code = '0;
        endcase
    end
endmodule

module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] insn,
    input  logic [31:0] code,
    output logic [63:0] imm
);
    logic unused_bits;
    assign unused_bits = ^{code[31:14], code[C_OP], code[C_OP_32], code[C_AMO], insn[6:0]};

    always_comb begin
        imm = '0;
        if (code[C_LUI] || code[C_AUIPC]) begin
            imm = {{32{insn[31]}}, insn[31:12], 12'b0};
        end else if (code[C_JAL]) begin
            imm = {{44{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
        end else if (code[C_OP_IMM] || code[C_OP_IMM_32] || code[C_JALR] ||
                     code[C_LOAD] || code[C_SYSTEM] || code[C_MISC_MEM]) begin
            imm = {{52{insn[31]}}, insn[31:20]};
        end else if (code[C_BRANCH]) begin
            imm = {{52{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
        end else if (code[C_STORE]) begin
            imm = {{52{insn[31]}}, insn[31:25], insn[11:7]};
        end
    end
endmodule

module decode_stage #(
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_insn,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_code,
    output logic [63:0]     out_imm,
    output logic            out_illegal
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t          state, state_next;
    logic [31:0]     skid_insn;
    logic [PC_W-1:0] skid_pc;
    logic [31:0]     src_insn;
    logic [PC_W-1:0] src_pc;
    logic [31:0]     dec_code;
    logic [63:0]     dec_imm;
    logic            in_xfer, out_xfer;
    logic            load_out, load_skid;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != SKID);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // The skid word always decodes ahead of anything fetch is presenting.
    assign src_insn = (state == SKID) ? skid_insn : in_insn;
    assign src_pc   = (state == SKID) ? skid_pc   : in_pc;

    opdecoder u_opdecoder (
        .opcode (src_insn[6:0]),
        .code   (dec_code)
    );

    imm_gen u_imm_gen (
        .insn (src_insn),
        .code (dec_code),
        .imm  (dec_imm)
    );

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    load_out   = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (in_xfer && out_xfer) begin
                    load_out = 1'b1;
                end else if (in_xfer) begin
                    load_skid  = 1'b1;
                    state_next = SKID;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            SKID: begin
                if (out_xfer) begin
                    load_out   = 1'b1;
                    state_next = FULL;
                end
            end
            default: state_next = EMPTY;
        endcase
        // A redirect discards both held words and any word arriving this cycle.
        if (flush) begin
            state_next = EMPTY;
            load_out   = 1'b0;
            load_skid  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_insn <= '0;
            skid_pc   <= '0;
        end else if (load_skid) begin
            skid_insn <= in_insn;
            skid_pc   <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_insn    <= '0;
            out_pc      <= '0;
            out_code    <= '0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
        end else if (load_out) begin
            out_insn    <= src_insn;
            out_pc      <= src_pc;
            out_code    <= dec_code;
            out_imm     <= dec_imm;
            out_illegal <= (dec_code == '0);
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [63:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [63:0] out_pc;
    logic [31:0] out_code;
    logic [63:0] out_imm;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    decode_stage #(.PC_W(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_insn     (in_insn),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_insn    (out_insn),
        .out_pc      (out_pc),
        .out_code    (out_code),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_insn = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if ({out_insn, out_pc, out_code, out_imm, out_illegal} !== '0) begin
            errors++; $display("FAIL reset_data: got insn=%h pc=%h code=%h imm=%h ill=%b expected all zero",
                               out_insn, out_pc, out_code, out_imm, out_illegal); end
        reset = 1'b0;
    endtask

    task automatic test_lui();
        in_valid = 1'b1; in_insn = 32'h12345037; in_pc = 64'h1000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lui_valid: got %b expected 1", out_valid); end
        checks++; if (out_imm !== 64'h0000000012345000) begin errors++; $display("FAIL lui_imm: got %h expected 0000000012345000", out_imm); end
        checks++; if (out_pc !== 64'h1000) begin errors++; $display("FAIL lui_pc: got %h expected 1000", out_pc); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL lui_illegal: got %b expected 0", out_illegal); end
        checks++; if (out_code !== 32'h1) begin errors++; $display("FAIL lui_code: got %h expected 00000001", out_code); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lui_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [5] = '{32'h800000B7, 32'hFFF00093, 32'hFE000EE3, 32'hFE112C23, 32'hFF1FF06F};
        logic [63:0] e [5] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                               64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFF0};
        logic [31:0] c [5] = '{32'h1, 32'h80, 32'h10, 32'h40, 32'h4};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_insn = w[i]; in_pc = 64'h2000 + 64'(4 * i);
            tick();
            checks++; if (out_valid !== 1'b1 || out_insn !== w[i] || in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_issue[%0d]: got valid=%b insn=%h rdy=%b expected 1 %h 1",
                                   i, out_valid, out_insn, in_ready, w[i]); end
            checks++; if (out_imm !== e[i]) begin errors++; $display("FAIL b2b_imm[%0d]: got %h expected %h", i, out_imm, e[i]); end
            checks++; if (out_code !== c[i]) begin errors++; $display("FAIL b2b_code[%0d]: got %h expected %h", i, out_code, c[i]); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_insn = 32'h00100093; in_pc = 64'h3000;
        tick();
        in_insn = 32'h00200093; in_pc = 64'h3004;
        tick();
        checks++; if (in_ready !== 1'b0 || out_insn !== 32'h00100093) begin
            errors++; $display("FAIL bp_skid: got rdy=%b insn=%h expected 0 00100093", in_ready, out_insn); end
        in_insn = 32'h00300093; in_pc = 64'h3008;
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_insn !== 32'h00100093 || out_pc !== 64'h3000) begin
            errors++; $display("FAIL bp_hold: got rdy=%b valid=%b insn=%h pc=%h expected 0 1 00100093 3000",
                               in_ready, out_valid, out_insn, out_pc); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_insn !== 32'h00200093 || out_pc !== 64'h3004 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_b: got insn=%h pc=%h rdy=%b expected 00200093 3004 1", out_insn, out_pc, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_insn !== 32'h00300093 || out_pc !== 64'h3008 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_c: got insn=%h pc=%h valid=%b expected 00300093 3008 1", out_insn, out_pc, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_insn = 32'h00500093; in_pc = 64'h4000;
        tick();
        in_insn = 32'h00600093; in_pc = 64'h4004;
        tick();
        in_insn = 32'h00700093; in_pc = 64'h4008; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: got valid=%b rdy=%b expected 0 1", out_valid, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: got %b expected 0", out_valid); end
        in_valid = 1'b1; in_insn = 32'h00800093; in_pc = 64'h5000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_insn !== 32'h00800093 || out_pc !== 64'h5000) begin
            errors++; $display("FAIL flush_resume: got valid=%b insn=%h pc=%h expected 1 00800093 5000",
                               out_valid, out_insn, out_pc); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_insn = 32'h00900093; in_pc = 64'h6000;
        tick();
        in_insn = 32'h00A00093; in_pc = 64'h6004;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_pre: got rdy=%b expected 0", in_ready); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_insn !== 32'h0) begin
            errors++; $display("FAIL areset_now: got valid=%b rdy=%b insn=%h expected 0 1 0", out_valid, in_ready, out_insn); end
        #2 reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_insn = 32'hFFFFFFFF; in_pc = 64'h7000;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_code !== 32'h0 || out_imm !== 64'h0) begin
            errors++; $display("FAIL illegal: got valid=%b ill=%b code=%h imm=%h expected 1 1 0 0",
                               out_valid, out_illegal, out_code, out_imm); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_drain: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_lui();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
